// File: rtl/rst_seq_pkg.sv
// -----------------------------------------------------------------------------
// rst_seq_pkg
// Shared definitions for the reset release sequencer.
//  - STATE_W      : width of the sequencer state / SEQ_STATE debug output
//  - ST_ASSERT    : all domains held in reset, first hold interval running
//  - ST_RELEASE   : domains being released one per hold interval
//  - ST_RUN       : every domain released, SEQ_DONE high
//  - ST_SOFT      : soft reset in progress (only reachable with RST_SEQ_SOFT_EN)
// The numeric codes are what software/benches see on SEQ_STATE, so they are
// fixed here rather than left to the enum's default numbering.
// -----------------------------------------------------------------------------
package rst_seq_pkg;

    localparam int STATE_W = 2;

    localparam logic [STATE_W-1:0] ST_ASSERT  = 2'd0;
    localparam logic [STATE_W-1:0] ST_RELEASE = 2'd1;
    localparam logic [STATE_W-1:0] ST_RUN     = 2'd2;
    localparam logic [STATE_W-1:0] ST_SOFT    = 2'd3;

    typedef enum logic [STATE_W-1:0] {
        S_ASSERT  = ST_ASSERT,
        S_RELEASE = ST_RELEASE,
        S_RUN     = ST_RUN,
        S_SOFT    = ST_SOFT
    } seq_state_e;

    // Width of the domain index register; at least one bit even for a
    // single domain so the register is never zero-width.
    function automatic int idx_width(input int num_domains);
        return (num_domains > 1) ? $clog2(num_domains) : 1;
    endfunction

endpackage

// File: rtl/rst_release_seq_if.sv
// -----------------------------------------------------------------------------
// rst_release_seq_if
// Groups the sequencer's handshake and reset outputs.
//  SOFT_RST_REQ  soft-reset request, level          (master -> slave)
//  SOFT_RST_ACK  soft-reset acknowledge, level      (slave  -> master)
//  DOM_RST_N     per-domain active-low resets       (slave  -> master)
//  SEQ_DONE      all domains released               (slave  -> master)
//  SEQ_STATE     sequencer state, debug             (slave  -> master)
// The sequencer (rst_release_seq) connects through the slave modport; whoever
// requests soft resets and observes the domain resets uses the master modport.
// -----------------------------------------------------------------------------
interface rst_release_seq_if
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 4
);

    logic                   SOFT_RST_REQ;
    logic                   SOFT_RST_ACK;
    logic [NUM_DOMAINS-1:0] DOM_RST_N;
    logic                   SEQ_DONE;
    logic [STATE_W-1:0]     SEQ_STATE;

    modport master (
        output SOFT_RST_REQ,
        input  SOFT_RST_ACK,
        input  DOM_RST_N,
        input  SEQ_DONE,
        input  SEQ_STATE
    );

    modport slave (
        input  SOFT_RST_REQ,
        output SOFT_RST_ACK,
        output DOM_RST_N,
        output SEQ_DONE,
        output SEQ_STATE
    );

endinterface

// File: rtl/rst_seq_hold_cnt.sv
// -----------------------------------------------------------------------------
// rst_seq_hold_cnt
// Hold-interval counter for the reset release sequencer.
//  clk  in   clock, rising edge
//  clr  in   synchronous clear (highest priority)
//  en   in   count enable
//  tc   out  terminal count: cnt == HOLD_CYCLES-1 (combinational from cnt)
// HOLD_CYCLES must not exceed 2**CNT_W so the terminal value is representable;
// the owner clears the counter on tc, so it never wraps.
// -----------------------------------------------------------------------------
module rst_seq_hold_cnt #(
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] cnt;

    // Clear dominates enable so a terminal-count clear and a count request on
    // the same edge always leave the counter at zero.
    always_ff @(posedge clk) begin
        if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == CNT_W'(HOLD_CYCLES - 1));

endmodule

// File: rtl/rst_release_seq.sv
// -----------------------------------------------------------------------------
// rst_release_seq
// Reset release sequencer. Fed by the reset synchronizer's output on RST, it
// holds every domain in reset for one hold interval, then releases the domain
// resets one at a time (index 0 first), HOLD_CYCLES apart, and finally raises
// SEQ_DONE together with the last domain.
//
// Ports
//  CLK      in   single clock, rising edge
//  RST      in   synchronous active-high reset, wins over everything
//  seq_if   slave modport of rst_release_seq_if:
//             SOFT_RST_REQ in, SOFT_RST_ACK out, DOM_RST_N out (registered),
//             SEQ_DONE out (registered), SEQ_STATE out (state register)
//
// Parameters
//  NUM_DOMAINS  number of sequenced domains (>=1)
//  HOLD_CYCLES  clock cycles per hold interval (>=1)
//  CNT_W        hold counter width, HOLD_CYCLES <= 2**CNT_W
//
// Configuration
//  RST_SEQ_SOFT_EN  when defined, a soft-reset request seen in RUN drops all
//                   domains, acknowledges, and re-runs the full sequence once
//                   the request is withdrawn. When undefined, the request is
//                   ignored and SOFT_RST_ACK is tied low; ports are identical.
// -----------------------------------------------------------------------------
module rst_release_seq
    import rst_seq_pkg::*;
#(
    parameter int NUM_DOMAINS = 4,
    parameter int HOLD_CYCLES = 16,
    parameter int CNT_W       = 8
) (
    input  logic                    CLK,
    input  logic                    RST,
    rst_release_seq_if.slave        seq_if
);

    localparam int IDX_W = idx_width(NUM_DOMAINS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DOMAINS - 1);

    seq_state_e             state;
    logic [IDX_W-1:0]       idx;
    logic [NUM_DOMAINS-1:0] dom_rst_n;
    logic                   seq_done;
    logic                   counting;
    logic                   hold_tc;

    // The hold counter only runs while a hold interval is in progress; in RUN,
    // SOFT and under reset it is parked at zero so every fresh interval
    // (including the one after a soft reset) starts from a clean count.
    assign counting = (state == S_ASSERT) || (state == S_RELEASE);

    rst_seq_hold_cnt #(
        .HOLD_CYCLES (HOLD_CYCLES),
        .CNT_W       (CNT_W)
    ) u_hold_cnt (
        .clk (CLK),
        .clr (RST || !counting || hold_tc),
        .en  (counting),
        .tc  (hold_tc)
    );

`ifdef RST_SEQ_SOFT_EN
    logic soft_ack;

    // Sequencer FSM with the soft-reset handshake. The request is only looked
    // at in RUN, so a request raised mid-sequence is simply taken one edge
    // after RUN is reached. Leaving SOFT behaves like a reset edge: the next
    // edge is the first edge of a brand-new ASSERT interval.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_ASSERT;
            dom_rst_n <= '0;
            seq_done  <= 1'b0;
            soft_ack  <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                S_ASSERT: begin
                    if (hold_tc) begin
                        state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (hold_tc) begin
                        dom_rst_n[idx] <= 1'b1;
                        if (idx == LAST_IDX) begin
                            state    <= S_RUN;
                            seq_done <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    if (seq_if.SOFT_RST_REQ) begin
                        state     <= S_SOFT;
                        dom_rst_n <= '0;
                        seq_done  <= 1'b0;
                        soft_ack  <= 1'b1;
                    end
                end
                S_SOFT: begin
                    if (!seq_if.SOFT_RST_REQ) begin
                        state    <= S_ASSERT;
                        soft_ack <= 1'b0;
                        idx      <= '0;
                    end
                end
                default: begin
                    state <= S_ASSERT;
                end
            endcase
        end
    end

    assign seq_if.SOFT_RST_ACK = soft_ack;
`else
    logic unused_soft_req;

    assign unused_soft_req = seq_if.SOFT_RST_REQ;

    // Sequencer FSM without soft reset: once RUN is reached only RST can
    // restart the sequence. SOFT is never entered; should the state register
    // ever hold it anyway, fall back to ASSERT.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state     <= S_ASSERT;
            dom_rst_n <= '0;
            seq_done  <= 1'b0;
            idx       <= '0;
        end else begin
            case (state)
                S_ASSERT: begin
                    if (hold_tc) begin
                        state <= S_RELEASE;
                    end
                end
                S_RELEASE: begin
                    if (hold_tc) begin
                        dom_rst_n[idx] <= 1'b1;
                        if (idx == LAST_IDX) begin
                            state    <= S_RUN;
                            seq_done <= 1'b1;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    state <= S_RUN;
                end
                default: begin
                    state <= S_ASSERT;
                end
            endcase
        end
    end

    assign seq_if.SOFT_RST_ACK = 1'b0;
`endif

    assign seq_if.DOM_RST_N = dom_rst_n;
    assign seq_if.SEQ_DONE  = seq_done;
    assign seq_if.SEQ_STATE = state;

endmodule

// File: tb/tb_rst_release_seq.sv
// -----------------------------------------------------------------------------
// tb_rst_release_seq
// Bench for rst_release_seq. Two instances share clock and reset:
//  dut_a : NUM_DOMAINS=4, HOLD_CYCLES=16 (soft request driven by the bench)
//  dut_b : NUM_DOMAINS=2, HOLD_CYCLES=1  (soft request tied low)
// A behavioural model tracks, per instance, how many edges have passed since
// the last reset (or soft-reset exit) and whether a soft reset is active; the
// expected outputs follow from that count by plain arithmetic. Directed
// scenarios add literal expectations, then a random phase exercises RST and
// soft requests. RST_SEQ_SOFT_EN selects which soft behaviour is expected.
// -----------------------------------------------------------------------------
module tb_rst_release_seq;
    import rst_seq_pkg::*;

    localparam int N_A = 4;
    localparam int H_A = 16;
    localparam int N_B = 2;
    localparam int H_B = 1;
    localparam int T_CAP = 1000000;

`ifdef RST_SEQ_SOFT_EN
    localparam bit SOFT_EN = 1'b1;
`else
    localparam bit SOFT_EN = 1'b0;
`endif

    logic clk_tb;
    logic rst_tb;
    logic req_tb;
    bit   check_en;

    int err_cnt;
    int chk_cnt;

    rst_release_seq_if #(.NUM_DOMAINS(N_A)) if_a ();
    rst_release_seq_if #(.NUM_DOMAINS(N_B)) if_b ();

    assign if_a.SOFT_RST_REQ = req_tb;
    assign if_b.SOFT_RST_REQ = 1'b0;

    rst_release_seq #(
        .NUM_DOMAINS (N_A),
        .HOLD_CYCLES (H_A),
        .CNT_W       (8)
    ) dut_a (
        .CLK    (clk_tb),
        .RST    (rst_tb),
        .seq_if (if_a.slave)
    );

    rst_release_seq #(
        .NUM_DOMAINS (N_B),
        .HOLD_CYCLES (H_B),
        .CNT_W       (4)
    ) dut_b (
        .CLK    (clk_tb),
        .RST    (rst_tb),
        .seq_if (if_b.slave)
    );

    initial clk_tb = 1'b0;
    always #5 clk_tb = ~clk_tb;

    // Model state: edges since the sequence (re)started, and soft-reset flag.
    int m_t_a;
    bit m_soft_a;
    int m_t_b;

    // Domain k is released once (k+2) hold intervals have elapsed.
    function automatic logic [31:0] expDom(input int t, input int n, input int h);
        logic [31:0] v;
        v = '0;
        for (int k = 0; k < n; k++) begin
            v[k] = (t >= (k + 2) * h);
        end
        return v;
    endfunction

    function automatic logic [31:0] expState(input int t, input int n, input int h);
        if (t < h) return 32'(ST_ASSERT);
        if (t < (n + 1) * h) return 32'(ST_RELEASE);
        return 32'(ST_RUN);
    endfunction

    // Model update: RST restarts the count; in RUN a request (soft build only)
    // enters soft reset; leaving soft reset restarts the count like RST does.
    always @(posedge clk_tb) begin
        if (rst_tb) begin
            m_t_a    <= 0;
            m_soft_a <= 1'b0;
        end else if (m_soft_a) begin
            if (!req_tb) begin
                m_soft_a <= 1'b0;
                m_t_a    <= 0;
            end
        end else if (SOFT_EN && (m_t_a >= (N_A + 1) * H_A) && req_tb) begin
            m_soft_a <= 1'b1;
        end else if (m_t_a < T_CAP) begin
            m_t_a <= m_t_a + 1;
        end
    end

    always @(posedge clk_tb) begin
        if (rst_tb) begin
            m_t_b <= 0;
        end else if (m_t_b < T_CAP) begin
            m_t_b <= m_t_b + 1;
        end
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare every output of both instances against the model.
    task automatic checkOutput();
        if (m_soft_a) begin
            checkVal("a.dom",   32'(if_a.DOM_RST_N),    32'h0);
            checkVal("a.done",  32'(if_a.SEQ_DONE),     32'h0);
            checkVal("a.ack",   32'(if_a.SOFT_RST_ACK), 32'h1);
            checkVal("a.state", 32'(if_a.SEQ_STATE),    32'(ST_SOFT));
        end else begin
            checkVal("a.dom",   32'(if_a.DOM_RST_N),    expDom(m_t_a, N_A, H_A));
            checkVal("a.done",  32'(if_a.SEQ_DONE),     32'(m_t_a >= (N_A + 1) * H_A));
            checkVal("a.ack",   32'(if_a.SOFT_RST_ACK), 32'h0);
            checkVal("a.state", 32'(if_a.SEQ_STATE),    expState(m_t_a, N_A, H_A));
        end
        checkVal("b.dom",   32'(if_b.DOM_RST_N),    expDom(m_t_b, N_B, H_B));
        checkVal("b.done",  32'(if_b.SEQ_DONE),     32'(m_t_b >= (N_B + 1) * H_B));
        checkVal("b.ack",   32'(if_b.SOFT_RST_ACK), 32'h0);
        checkVal("b.state", 32'(if_b.SEQ_STATE),    expState(m_t_b, N_B, H_B));
    endtask

    always @(negedge clk_tb) begin
        if (check_en) checkOutput();
    end

    // Drive inputs, let n rising edges pass, return on the following falling edge.
    task automatic applyStimulus(input bit rst_v, input bit req_v, input int n);
        rst_tb = rst_v;
        req_tb = req_v;
        repeat (n) @(posedge clk_tb);
        @(negedge clk_tb);
    endtask

    initial begin
        err_cnt  = 0;
        chk_cnt  = 0;
        check_en = 1'b0;

        // Power-up: RST for 3 edges, then literal release points.
        applyStimulus(1'b1, 1'b0, 1);
        check_en = 1'b1;
        applyStimulus(1'b1, 1'b0, 2);
        checkVal("pwr.a.dom.rst", 32'(if_a.DOM_RST_N), 32'h0);
        checkVal("pwr.a.state.rst", 32'(if_a.SEQ_STATE), 32'(ST_ASSERT));
        applyStimulus(1'b0, 1'b0, 1);
        checkVal("h1.b.dom@1", 32'(if_b.DOM_RST_N), 32'h0);
        applyStimulus(1'b0, 1'b0, 1);
        checkVal("h1.b.dom@2", 32'(if_b.DOM_RST_N), 32'h1);
        checkVal("h1.b.done@2", 32'(if_b.SEQ_DONE), 32'h0);
        applyStimulus(1'b0, 1'b0, 1);
        checkVal("h1.b.dom@3", 32'(if_b.DOM_RST_N), 32'h3);
        checkVal("h1.b.done@3", 32'(if_b.SEQ_DONE), 32'h1);
        applyStimulus(1'b0, 1'b0, 28);
        checkVal("pwr.a.dom@31", 32'(if_a.DOM_RST_N), 32'h0);
        applyStimulus(1'b0, 1'b0, 1);
        checkVal("pwr.a.dom@32", 32'(if_a.DOM_RST_N), 32'h1);
        applyStimulus(1'b0, 1'b0, 16);
        checkVal("pwr.a.dom@48", 32'(if_a.DOM_RST_N), 32'h3);
        applyStimulus(1'b0, 1'b0, 16);
        checkVal("pwr.a.dom@64", 32'(if_a.DOM_RST_N), 32'h7);
        applyStimulus(1'b0, 1'b0, 15);
        checkVal("pwr.a.done@79", 32'(if_a.SEQ_DONE), 32'h0);
        applyStimulus(1'b0, 1'b0, 1);
        checkVal("pwr.a.dom@80", 32'(if_a.DOM_RST_N), 32'hf);
        checkVal("pwr.a.done@80", 32'(if_a.SEQ_DONE), 32'h1);
        checkVal("pwr.a.state@80", 32'(if_a.SEQ_STATE), 32'(ST_RUN));

        // Mid-sequence reset at edge 50, then a full restart.
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 49);
        checkVal("mid.a.dom@49", 32'(if_a.DOM_RST_N), 32'h3);
        applyStimulus(1'b1, 1'b0, 1);
        checkVal("mid.a.dom@50", 32'(if_a.DOM_RST_N), 32'h0);
        checkVal("mid.a.state@50", 32'(if_a.SEQ_STATE), 32'(ST_ASSERT));
        applyStimulus(1'b0, 1'b0, 31);
        checkVal("mid.a.dom+31", 32'(if_a.DOM_RST_N), 32'h0);
        applyStimulus(1'b0, 1'b0, 1);
        checkVal("mid.a.dom+32", 32'(if_a.DOM_RST_N), 32'h1);
        applyStimulus(1'b0, 1'b0, 48);
        checkVal("mid.a.done+80", 32'(if_a.SEQ_DONE), 32'h1);

`ifdef RST_SEQ_SOFT_EN
        // Soft request in RUN for 5 edges, then full re-sequence.
        applyStimulus(1'b0, 1'b1, 1);
        checkVal("soft.a.ack", 32'(if_a.SOFT_RST_ACK), 32'h1);
        checkVal("soft.a.dom", 32'(if_a.DOM_RST_N), 32'h0);
        checkVal("soft.a.done", 32'(if_a.SEQ_DONE), 32'h0);
        checkVal("soft.a.state", 32'(if_a.SEQ_STATE), 32'(ST_SOFT));
        applyStimulus(1'b0, 1'b1, 4);
        checkVal("soft.a.ack.held", 32'(if_a.SOFT_RST_ACK), 32'h1);
        applyStimulus(1'b0, 1'b0, 1);
        checkVal("soft.a.ack.drop", 32'(if_a.SOFT_RST_ACK), 32'h0);
        checkVal("soft.a.state.exit", 32'(if_a.SEQ_STATE), 32'(ST_ASSERT));
        applyStimulus(1'b0, 1'b0, 79);
        checkVal("soft.a.done+79", 32'(if_a.SEQ_DONE), 32'h0);
        applyStimulus(1'b0, 1'b0, 1);
        checkVal("soft.a.done+80", 32'(if_a.SEQ_DONE), 32'h1);
        checkVal("soft.a.dom+80", 32'(if_a.DOM_RST_N), 32'hf);

        // Request raised at edge 40 and held: ignored until RUN at 80.
        applyStimulus(1'b1, 1'b0, 1);
        applyStimulus(1'b0, 1'b0, 39);
        applyStimulus(1'b0, 1'b1, 41);
        checkVal("early.a.state@80", 32'(if_a.SEQ_STATE), 32'(ST_RUN));
        checkVal("early.a.ack@80", 32'(if_a.SOFT_RST_ACK), 32'h0);
        applyStimulus(1'b0, 1'b1, 1);
        checkVal("early.a.state@81", 32'(if_a.SEQ_STATE), 32'(ST_SOFT));
        checkVal("early.a.ack@81", 32'(if_a.SOFT_RST_ACK), 32'h1);
        applyStimulus(1'b0, 1'b0, 1);
`else
        // Soft request has no effect in this build.
        applyStimulus(1'b0, 1'b1, 1);
        checkVal("nosoft.a.ack", 32'(if_a.SOFT_RST_ACK), 32'h0);
        checkVal("nosoft.a.state", 32'(if_a.SEQ_STATE), 32'(ST_RUN));
        checkVal("nosoft.a.dom", 32'(if_a.DOM_RST_N), 32'hf);
        applyStimulus(1'b0, 1'b1, 4);
        checkVal("nosoft.a.state.held", 32'(if_a.SEQ_STATE), 32'(ST_RUN));
        applyStimulus(1'b0, 1'b0, 1);
        checkVal("nosoft.a.done", 32'(if_a.SEQ_DONE), 32'h1);
`endif

        // Random phase: occasional RST, soft request toggling as a level.
        begin
            bit req_v;
            bit rst_v;
            req_v = 1'b0;
            for (int i = 0; i < 3000; i++) begin
                rst_v = ($urandom_range(0, 299) == 0);
                if ($urandom_range(0, 11) == 0) req_v = ~req_v;
                applyStimulus(rst_v, req_v, 1);
            end
        end

        check_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
